// File: rtl/zbb_pkg.sv
// Shared constants for the RV32IM_Zbb execute-stage bit-manipulation units.
// Op codes, widths and helpers used by the Zbs single-bit path.
package zbb_pkg;

   localparam int XLEN = 32;

   typedef logic [1:0] zbs_op_t;

   localparam zbs_op_t OP_BSET = 2'b00;
   localparam zbs_op_t OP_BCLR = 2'b01;
   localparam zbs_op_t OP_BINV = 2'b10;
   localparam zbs_op_t OP_BEXT = 2'b11;

   // Zbb/Zbs instruction encoding fields
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] F7_BSET    = 7'b0010100;
   localparam logic [6:0] F7_BCLR    = 7'b0100100;
   localparam logic [6:0] F7_BINV    = 7'b0110100;
   localparam logic [6:0] F7_BEXT    = 7'b0100100;
   localparam logic [2:0] F3_BSCI    = 3'b001;
   localparam logic [2:0] F3_BEXT    = 3'b101;

   function automatic int idx_w(input int w);
      return $clog2(w);
   endfunction

   localparam int XLEN_IDX_W = idx_w(XLEN);

endpackage

// File: rtl/bit_idx_dec.sv
// Bit-index to one-hot decoder, inverse of the trailing-zero encoder.
// Purely combinational; shared with the shift/rotate path.
module bit_idx_dec #(
   parameter int IDX_W = 5
) (
   input  logic [IDX_W-1:0]    idx,
   output logic [2**IDX_W-1:0] onehot
);

   for (genvar i = 0; i < 2**IDX_W; i++) begin : g_bit
      assign onehot[i] = (idx == IDX_W'(i));
   end

endmodule

// File: rtl/zbs_bit_decoder.sv
// Two-stage Zbs unit: S1 registers op/rs1/one-hot mask, S2 registers
// the BSET/BCLR/BINV/BEXT result. Valid/ready on both sides.
module zbs_bit_decoder
   import zbb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int IDX_W      = idx_w(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            in_op,
   input  logic [DATA_WIDTH-1:0] in_rs1,
   input  logic [DATA_WIDTH-1:0] in_rs2,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_result,
   output logic [DATA_WIDTH-1:0] out_mask
);

   logic                  s1_valid;
   zbs_op_t               s1_op;
   logic [DATA_WIDTH-1:0] s1_rs1;
   logic [DATA_WIDTH-1:0] s1_mask;

   logic                  s2_valid;
   logic [DATA_WIDTH-1:0] s2_result;
   logic [DATA_WIDTH-1:0] s2_mask;

   logic                  s2_free;
   logic                  s1_adv;
   logic                  accept;
   logic [DATA_WIDTH-1:0] dec_mask;
   logic [DATA_WIDTH-1:0] op_result;

   logic unused_rs2;
   assign unused_rs2 = ^in_rs2[DATA_WIDTH-1:IDX_W];

   bit_idx_dec #(
      .IDX_W (IDX_W)
   ) u_dec (
      .idx    (in_rs2[IDX_W-1:0]),
      .onehot (dec_mask)
   );

   // in_ready must not look at in_valid or flush
   assign s2_free  = !s2_valid || out_ready;
   assign s1_adv   = s1_valid && s2_free;
   assign in_ready = !s1_valid || s2_free;
   assign accept   = in_valid && in_ready && !flush;

   always_comb begin
      op_result = '0;
      unique case (s1_op)
         OP_BSET: op_result = s1_rs1 | s1_mask;
         OP_BCLR: op_result = s1_rs1 & ~s1_mask;
         OP_BINV: op_result = s1_rs1 ^ s1_mask;
         OP_BEXT: op_result = {{(DATA_WIDTH-1){1'b0}},
                               |(s1_rs1 & s1_mask)};
         default: op_result = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_op    <= OP_BSET;
         s1_rs1   <= '0;
         s1_mask  <= '0;
      end else if (flush) begin
         s1_valid <= 1'b0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_op    <= in_op;
         s1_rs1   <= in_rs1;
         s1_mask  <= dec_mask;
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   // S2 data only moves when S2 is free, so a stalled result holds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         s2_result <= '0;
         s2_mask   <= '0;
      end else if (flush) begin
         s2_valid <= 1'b0;
      end else if (s1_adv) begin
         s2_valid  <= 1'b1;
         s2_result <= op_result;
         s2_mask   <= s1_mask;
      end else if (out_ready) begin
         s2_valid <= 1'b0;
      end
   end

   assign out_valid  = s2_valid;
   assign out_result = s2_result;
   assign out_mask   = s2_mask;

endmodule

// File: tb/tb_zbs_bit_decoder.sv
// Directed and random bench for zbs_bit_decoder against a queue model.
// Items age per edge; the oldest item is visible one edge after capture.
module tb_zbs_bit_decoder;
   import zbb_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [31:0] in_rs1;
   logic [31:0] in_rs2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [31:0] out_mask;

   zbs_bit_decoder #(.DATA_WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_mask   (out_mask)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [31:0] mask;
      int          age;
   } item_t;

   typedef struct {
      int          cyc;
      logic [31:0] res;
      logic [31:0] mask;
   } log_t;

   item_t mq[$];
   log_t  lg[$];
   int    checks = 0;
   int    passed = 0;
   int    cyc_n  = 0;
   int    n_hs   = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      assert (got === exp) passed++;
      else $error("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   function automatic logic [31:0] pow2(input logic [31:0] b);
      int unsigned idx;
      idx = b % 32;
      return 32'd1 << idx;
   endfunction

   // Arithmetic view: setting a clear bit adds 2^idx, clearing subtracts
   function automatic logic [31:0] ref_res(input logic [1:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      int unsigned idx;
      logic [31:0] p;
      logic        bt;
      idx = b % 32;
      p   = pow2(b);
      bt  = ((a / p) % 2) == 1;
      case (op)
         OP_BSET: return bt ? a : a + p;
         OP_BCLR: return bt ? a - p : a;
         OP_BINV: return bt ? a - p : a + p;
         default: return {31'd0, bt};
      endcase
   endfunction

   task automatic cyc(input logic v, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic ordy, input logic fl);
      logic exp_rdy, exp_v, acc, pop;
      in_valid  = v;
      in_op     = op;
      in_rs1    = a;
      in_rs2    = b;
      out_ready = ordy;
      flush     = fl;
      #4;
      exp_rdy = (mq.size() < 2) || ordy;
      exp_v   = (mq.size() > 0) && (mq[0].age >= 1);
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(exp_v));
      if (exp_v && out_valid) begin
         check("out_result", out_result, mq[0].res);
         check("out_mask", out_mask, mq[0].mask);
      end
      if (out_valid && ordy)
         lg.push_back('{cyc_n, out_result, out_mask});
      if (v && in_ready && !fl) n_hs++;
      acc = v && exp_rdy && !fl;
      pop = exp_v && ordy;
      @(posedge clk);
      foreach (mq[i]) mq[i].age++;
      if (fl) begin
         mq.delete();
      end else begin
         if (pop) void'(mq.pop_front());
         if (acc) mq.push_back('{ref_res(op, a, b), pow2(b), 0});
      end
      cyc_n++;
      #1;
   endtask

   task automatic idle(input int n, input logic ordy);
      for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, '0, '0, ordy, 1'b0);
   endtask

   initial begin
      int          base, c0, hs0;
      logic [31:0] held;
      logic [1:0]  rop;
      logic [31:0] ra, rb;

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
      in_op = 2'b00; in_rs1 = '0; in_rs2 = '0; out_ready = 1'b0;
      #3;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_result", out_result, 32'd0);
      check("rst_out_mask", out_mask, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic ops back-to-back
      base = lg.size();
      c0   = cyc_n;
      cyc(1'b1, OP_BSET, 32'h0000_00F0, 32'd3,  1'b1, 1'b0);
      cyc(1'b1, OP_BCLR, 32'h0000_00F0, 32'd4,  1'b1, 1'b0);
      cyc(1'b1, OP_BINV, 32'h0000_00F0, 32'd31, 1'b1, 1'b0);
      cyc(1'b1, OP_BEXT, 32'h0000_00F0, 32'd5,  1'b1, 1'b0);
      idle(4, 1'b1);
      check("basic_count", 32'(lg.size() - base), 32'd4);
      if (lg.size() - base == 4) begin
         check("bset_res", lg[base].res,   32'h0000_00F8);
         check("bclr_res", lg[base+1].res, 32'h0000_00E0);
         check("binv_res", lg[base+2].res, 32'h8000_00F0);
         check("bext_res", lg[base+3].res, 32'h0000_0001);
         check("binv_mask", lg[base+2].mask, 32'h8000_0000);
         for (int i = 0; i < 4; i++)
            check("basic_lat", 32'(lg[base+i].cyc), 32'(c0 + i + 2));
      end

      // Index truncation
      base = lg.size();
      cyc(1'b1, OP_BSET, 32'd0, 32'hFFFF_FFE1, 1'b1, 1'b0);
      idle(3, 1'b1);
      check("trunc_count", 32'(lg.size() - base), 32'd1);
      if (lg.size() > base) begin
         check("trunc_res", lg[base].res, 32'h0000_0002);
         check("trunc_mask", lg[base].mask, 32'h0000_0002);
      end

      // Backpressure
      hs0 = n_hs;
      cyc(1'b1, OP_BSET, 32'h0, 32'd0,  1'b0, 1'b0);
      cyc(1'b1, OP_BINV, 32'h1, 32'd31, 1'b0, 1'b0);
      cyc(1'b1, OP_BCLR, 32'hF, 32'd2,  1'b0, 1'b0);
      check("bp_accepts", 32'(n_hs - hs0), 32'd2);
      held = out_result;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_stable", out_result, held);
      end
      base = lg.size();
      idle(4, 1'b1);
      check("bp_drain", 32'(lg.size() - base), 32'd2);
      if (lg.size() - base == 2) begin
         check("bp_first", lg[base].res, 32'h0000_0001);
         check("bp_second", lg[base+1].res, 32'h8000_0001);
      end

      // Flush with both stages full
      cyc(1'b1, OP_BSET, 32'h0, 32'd7, 1'b0, 1'b0);
      cyc(1'b1, OP_BSET, 32'h0, 32'd8, 1'b0, 1'b0);
      base = lg.size();
      cyc(1'b1, OP_BSET, 32'h0, 32'd9, 1'b0, 1'b1);
      check("flush_valid", 32'(out_valid), 32'd0);
      check("flush_ready", 32'(in_ready), 32'd1);
      idle(4, 1'b1);
      check("flush_none", 32'(lg.size() - base), 32'd0);

      // Flush overriding an accept into an empty pipe
      cyc(1'b1, OP_BINV, 32'h0, 32'd1, 1'b1, 1'b1);
      idle(3, 1'b1);
      check("flush_acc", 32'(lg.size() - base), 32'd0);

      // Asynchronous reset mid-stream
      cyc(1'b1, OP_BINV, 32'h0, 32'd12, 1'b0, 1'b0);
      cyc(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
      check("mid_valid_pre", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_valid", 32'(out_valid), 32'd0);
      check("mid_result", out_result, 32'd0);
      check("mid_mask", out_mask, 32'd0);
      check("mid_ready", 32'(in_ready), 32'd1);
      mq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle(3, 1'b1);

      // Random traffic with idx 0/31 corners
      for (int n = 0; n < 10000; n++) begin
         rop = 2'($urandom_range(3));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(7))
            0: rb[4:0] = 5'd0;
            1: rb[4:0] = 5'd31;
            default: ;
         endcase
         cyc($urandom_range(9) < 7, rop, ra, rb,
             $urandom_range(9) < 7, $urandom_range(63) == 0);
      end
      idle(4, 1'b1);
      check("rand_empty", 32'(out_valid), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
